// File: rtl/sort_scheduler.sv
// rtl/sort_scheduler.sv - round-robin shared bubble-sort engine
// One compare/swap per cycle over a captured array, early exit on a swap-free pass.
module sort_scheduler #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_ELEM = 10,
  parameter int DATA_W   = 4,
  localparam int IDW     = $clog2(NUM_REQ),
  localparam int SWW     = $clog2(NUM_ELEM*(NUM_ELEM-1)/2+1)
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic [NUM_REQ-1:0]                  req_i,
  input  logic [NUM_REQ*NUM_ELEM*DATA_W-1:0]  data_i,
  output logic [NUM_REQ-1:0]                  gnt_o,
  output logic                                busy_o,
  output logic                                done_o,
  output logic [IDW-1:0]                      done_id_o,
  output logic [NUM_ELEM*DATA_W-1:0]          sorted_o,
  output logic [SWW-1:0]                      swaps_o
);

  localparam int KW = $clog2(NUM_ELEM);

  typedef enum logic [1:0] {IDLE, LOAD, SORT, DONE} state_t;

  state_t            state;
  logic [IDW-1:0]    last;
  logic [IDW-1:0]    win;
  logic              win_found;
  int                rr_idx;
  logic [DATA_W-1:0] arr [NUM_ELEM];
  logic [KW-1:0]     p;
  logic [KW-1:0]     k;
  logic [KW-1:0]     kp1;
  logic              pass_swap;
  logic [DATA_W-1:0] a_lo;
  logic [DATA_W-1:0] a_hi;
  logic              do_swap;
  logic              pass_any;
  logic              last_cmp;
  logic              final_pass;

  // Search starts just after the previous winner and wraps around.
  always_comb begin
    win       = '0;
    win_found = 1'b0;
    rr_idx    = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      rr_idx = (int'(last) + i) % NUM_REQ;
      if (!win_found && req_i[rr_idx]) begin
        win_found = 1'b1;
        win       = IDW'(rr_idx);
      end
    end
  end

  always_comb begin
    kp1        = k + KW'(1);
    a_lo       = arr[k];
    a_hi       = arr[kp1];
    do_swap    = (a_lo > a_hi);
    pass_any   = pass_swap | do_swap;
    last_cmp   = (k == (KW'(NUM_ELEM-2) - p));
    final_pass = (p == KW'(NUM_ELEM-2));
  end

  for (genvar e = 0; e < NUM_ELEM; e++) begin : g_out
    assign sorted_o[e*DATA_W +: DATA_W] = arr[e];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      last      <= IDW'(NUM_REQ-1);
      gnt_o     <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      done_id_o <= '0;
      swaps_o   <= '0;
      p         <= '0;
      k         <= '0;
      pass_swap <= 1'b0;
      for (int e = 0; e < NUM_ELEM; e++) arr[e] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            gnt_o  <= NUM_REQ'(1) << win;
            last   <= win;
            busy_o <= 1'b1;
            state  <= LOAD;
          end
        end
        LOAD: begin
          gnt_o     <= '0;
          p         <= '0;
          k         <= '0;
          pass_swap <= 1'b0;
          swaps_o   <= '0;
          for (int e = 0; e < NUM_ELEM; e++)
            arr[e] <= data_i[(int'(last)*NUM_ELEM + e)*DATA_W +: DATA_W];
          state <= SORT;
        end
        SORT: begin
          if (do_swap) begin
            arr[k]   <= a_hi;
            arr[kp1] <= a_lo;
            swaps_o  <= swaps_o + SWW'(1);
          end
          if (last_cmp) begin
            if (!pass_any || final_pass) begin
              done_o    <= 1'b1;
              done_id_o <= last;
              state     <= DONE;
            end else begin
              p         <= p + KW'(1);
              k         <= '0;
              pass_swap <= 1'b0;
            end
          end else begin
            k         <= kp1;
            pass_swap <= pass_any;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          gnt_o  <= '0;
          busy_o <= 1'b0;
          done_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
